// File: rtl/ex_alu_branch_unit_pkg.sv
// ex_alu_branch_unit_pkg
// Shared constants for the execute-stage ALU/branch slice:
//   - ALU opcodes (ARM data-processing bits 24:21)
//   - ARM condition codes
//   - bit positions inside every 4-bit flag bus ({Z, C, N, V})
package ex_alu_branch_unit_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_alu_core.sv
// ex_alu_core
// Combinational 32-bit ARM ALU with NZCV generation.
// Ports:
//   a_i, b_i     operands (Rn, shifter output)
//   op_i         data-processing opcode
//   flags_i      current registered flags (carry-in, logical-op C/V)
//   result_o     ALU result
//   alu_flags_o  {Z, C, N, V} produced by this op
module ex_alu_core
    import ex_alu_branch_unit_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    input  logic [3:0]  flags_i,
    output logic [31:0] result_o,
    output logic [3:0]  alu_flags_o
);

    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [32:0] sum;
    logic        is_arith;
    logic        carry_in;

    assign carry_in = flags_i[FLAG_C];

    // Every arithmetic op is folded into one adder as x + y + cin, with
    // subtraction expressed as x + ~y + 1 so C=1 means "no borrow".
    always_comb begin
        add_x    = a_i;
        add_y    = b_i;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        unique case (op_i)
            OP_SUB, OP_CMP: begin add_y = ~b_i; add_cin = 1'b1; end
            OP_RSB:         begin add_x = b_i; add_y = ~a_i; add_cin = 1'b1; end
            OP_ADD, OP_CMN: begin add_cin = 1'b0; end
            OP_ADC:         begin add_cin = carry_in; end
            OP_SBC:         begin add_y = ~b_i; add_cin = carry_in; end
            OP_RSC:         begin add_x = b_i; add_y = ~a_i; add_cin = carry_in; end
            default:        begin is_arith = 1'b0; end
        endcase
    end

    assign sum = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    // Result select; compare/test ops still produce a value, the pipeline
    // simply never writes it back.
    always_comb begin
        result_o = sum[31:0];
        unique case (op_i)
            OP_AND, OP_TST: result_o = a_i & b_i;
            OP_EOR, OP_TEQ: result_o = a_i ^ b_i;
            OP_ORR:         result_o = a_i | b_i;
            OP_MOV:         result_o = b_i;
            OP_BIC:         result_o = a_i & ~b_i;
            OP_MVN:         result_o = ~b_i;
            default:        result_o = sum[31:0];
        endcase
    end

    // Logical ops pass the old C and V through untouched. V is the signed
    // overflow of the pair actually fed to the adder (after inversion).
    always_comb begin
        alu_flags_o         = 4'b0000;
        alu_flags_o[FLAG_Z] = (result_o == 32'd0);
        alu_flags_o[FLAG_N] = result_o[31];
        if (is_arith) begin
            alu_flags_o[FLAG_C] = sum[32];
            alu_flags_o[FLAG_V] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
        end else begin
            alu_flags_o[FLAG_C] = flags_i[FLAG_C];
            alu_flags_o[FLAG_V] = flags_i[FLAG_V];
        end
    end

endmodule

// File: rtl/ex_alu_branch_unit.sv
// ex_alu_branch_unit
// Execute-stage datapath core: ALU, persistent flag register, ARM condition
// evaluation, branch target adder and B/BL handling.
// Ports:
//   CLK, CLR             clock (rising), async active-high reset
//   a_i, b_i, op_i, s_i  ALU operands, opcode, set-flags of the EX instruction
//   cond_i, b_instr_i, bl_instr_i, pc4_i, offset_i   branch info from ID
//   result_o, alu_flags_o, flags_o                   ALU result and flags
//   cond_true_o, target_o, taken_o, link_we_o        branch decision outputs
module ex_alu_branch_unit
    import ex_alu_branch_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  op_i,
    input  logic        s_i,
    input  logic [3:0]  cond_i,
    input  logic        b_instr_i,
    input  logic        bl_instr_i,
    input  logic [31:0] pc4_i,
    input  logic [23:0] offset_i,
    output logic [31:0] result_o,
    output logic [3:0]  alu_flags_o,
    output logic [3:0]  flags_o,
    output logic        cond_true_o,
    output logic [31:0] target_o,
    output logic        taken_o,
    output logic        link_we_o
);

    logic [3:0] eff_flags;
    logic       fz, fc, fn, fv;

    ex_alu_core u_alu (
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .flags_i     (flags_o),
        .result_o    (result_o),
        .alu_flags_o (alu_flags_o)
    );

    // Persistent NZCV register, updated only by flag-setting instructions.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            flags_o <= 4'b0000;
        end else if (s_i) begin
            flags_o <= alu_flags_o;
        end
    end

    // A flag-setting instruction in EX forwards its flags to the branch in ID
    // in the same cycle, otherwise the branch sees the registered flags.
    assign eff_flags = s_i ? alu_flags_o : flags_o;
    assign fz = eff_flags[FLAG_Z];
    assign fc = eff_flags[FLAG_C];
    assign fn = eff_flags[FLAG_N];
    assign fv = eff_flags[FLAG_V];

    // ARM condition evaluator.
    always_comb begin
        cond_true_o = 1'b0;
        unique case (cond_i)
            COND_EQ: cond_true_o = fz;
            COND_NE: cond_true_o = !fz;
            COND_CS: cond_true_o = fc;
            COND_CC: cond_true_o = !fc;
            COND_MI: cond_true_o = fn;
            COND_PL: cond_true_o = !fn;
            COND_VS: cond_true_o = fv;
            COND_VC: cond_true_o = !fv;
            COND_HI: cond_true_o = fc && !fz;
            COND_LS: cond_true_o = !fc || fz;
            COND_GE: cond_true_o = (fn == fv);
            COND_LT: cond_true_o = (fn != fv);
            COND_GT: cond_true_o = !fz && (fn == fv);
            COND_LE: cond_true_o = fz || (fn != fv);
            COND_AL: cond_true_o = 1'b1;
            COND_NV: cond_true_o = 1'b0;
            default: cond_true_o = 1'b0;
        endcase
    end

    // Word offset is sign-extended and scaled to bytes; wraps mod 2^32.
    assign target_o = pc4_i + ({{8{offset_i[23]}}, offset_i} << 2);

    // B+BL together naturally behaves as BL. Both strobes are held low while
    // in reset so no stray redirect or R14 write escapes.
    always_comb begin
        taken_o   = 1'b0;
        link_we_o = 1'b0;
        if (!CLR) begin
            taken_o   = cond_true_o && (b_instr_i || bl_instr_i);
            link_we_o = cond_true_o && bl_instr_i;
        end
    end

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// tb_ex_alu_branch_unit
// Directed self-checking bench for ex_alu_branch_unit with hand-computed
// expected values. Inputs change just after a rising edge, outputs are
// sampled a little later, well away from the next edge.
module tb_ex_alu_branch_unit;

    logic        CLK;
    logic        CLR;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [3:0]  op_i;
    logic        s_i;
    logic [3:0]  cond_i;
    logic        b_instr_i;
    logic        bl_instr_i;
    logic [31:0] pc4_i;
    logic [23:0] offset_i;
    logic [31:0] result_o;
    logic [3:0]  alu_flags_o;
    logic [3:0]  flags_o;
    logic        cond_true_o;
    logic [31:0] target_o;
    logic        taken_o;
    logic        link_we_o;

    int compared;
    int mismatched;

    ex_alu_branch_unit dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_i        (op_i),
        .s_i         (s_i),
        .cond_i      (cond_i),
        .b_instr_i   (b_instr_i),
        .bl_instr_i  (bl_instr_i),
        .pc4_i       (pc4_i),
        .offset_i    (offset_i),
        .result_o    (result_o),
        .alu_flags_o (alu_flags_o),
        .flags_o     (flags_o),
        .cond_true_o (cond_true_o),
        .target_o    (target_o),
        .taken_o     (taken_o),
        .link_we_o   (link_we_o)
    );

    // 10-unit clock period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive the EX-side ALU inputs and let combinational logic settle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic s);
        op_i = op;
        a_i  = a;
        b_i  = b;
        s_i  = s;
        #1;
    endtask

    // Drive the ID-side branch inputs.
    task automatic applyBranch(input logic [3:0] cond, input logic b, input logic bl,
                               input logic [31:0] pc4, input logic [23:0] off);
        cond_i     = cond;
        b_instr_i  = b;
        bl_instr_i = bl;
        pc4_i      = pc4;
        offset_i   = off;
        #1;
    endtask

    // Advance through one rising edge and step slightly past it.
    task automatic stepEdge();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        CLR        = 1'b1;
        a_i = 32'd0; b_i = 32'd0; op_i = 4'b0000; s_i = 1'b0;
        cond_i = 4'b1110; b_instr_i = 1'b1; bl_instr_i = 1'b1;
        pc4_i = 32'd0; offset_i = 24'd0;

        #2;
        checkOutput("reset_flags", {28'd0, flags_o}, 32'd0);
        checkOutput("reset_taken", {31'd0, taken_o}, 32'd0);
        checkOutput("reset_link", {31'd0, link_we_o}, 32'd0);

        stepEdge();
        CLR = 1'b0;
        applyBranch(4'b1110, 1'b0, 1'b0, 32'd0, 24'd0);

        // ADD overflow: 0x7FFFFFFF + 1
        applyStimulus(4'b0100, 32'h7FFF_FFFF, 32'd1, 1'b1);
        checkOutput("add_ovf_result", result_o, 32'h8000_0000);
        checkOutput("add_ovf_flags", {28'd0, alu_flags_o}, 32'h3);
        stepEdge();
        applyStimulus(4'b0100, 32'd0, 32'd1, 1'b0);
        checkOutput("add_ovf_latched", {28'd0, flags_o}, 32'h3);

        // Async reset with nonzero flags, away from any edge
        applyBranch(4'b1110, 1'b1, 1'b1, 32'h20, 24'd3);
        checkOutput("pre_clr_link", {31'd0, link_we_o}, 32'd1);
        CLR = 1'b1;
        #1;
        checkOutput("clr_async_flags", {28'd0, flags_o}, 32'd0);
        checkOutput("clr_taken", {31'd0, taken_o}, 32'd0);
        checkOutput("clr_link", {31'd0, link_we_o}, 32'd0);
        stepEdge();
        CLR = 1'b0;
        applyBranch(4'b1110, 1'b0, 1'b0, 32'd0, 24'd0);

        // CMP equal: Z=1, C=1
        applyStimulus(4'b1010, 32'd5, 32'd5, 1'b1);
        checkOutput("cmp_eq_result", result_o, 32'd0);
        checkOutput("cmp_eq_flags", {28'd0, alu_flags_o}, 32'hC);
        stepEdge();
        checkOutput("cmp_eq_latched", {28'd0, flags_o}, 32'hC);

        // CMP 3,5: negative with borrow (flags still C=1 from previous)
        applyStimulus(4'b1010, 32'd3, 32'd5, 1'b0);
        checkOutput("cmp_lt_result", result_o, 32'hFFFF_FFFE);
        checkOutput("cmp_lt_flags", {28'd0, alu_flags_o}, 32'h2);

        // Carry-in from registered C=1
        applyStimulus(4'b0101, 32'd1, 32'd1, 1'b0);
        checkOutput("adc_c1", result_o, 32'd3);
        applyStimulus(4'b0110, 32'd5, 32'd2, 1'b0);
        checkOutput("sbc_c1", result_o, 32'd3);
        applyStimulus(4'b0011, 32'd1, 32'd3, 1'b0);
        checkOutput("rsb_result", result_o, 32'd2);
        checkOutput("rsb_flags", {28'd0, alu_flags_o}, 32'h4);
        applyStimulus(4'b1111, 32'd0, 32'd0, 1'b0);
        checkOutput("mvn_result", result_o, 32'hFFFF_FFFF);
        checkOutput("mvn_flags", {28'd0, alu_flags_o}, 32'h6);
        applyStimulus(4'b1110, 32'hF0F0_F0F0, 32'hFF00_0000, 1'b0);
        checkOutput("bic_result", result_o, 32'h00F0_F0F0);
        applyStimulus(4'b0001, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0);
        checkOutput("eor_result", result_o, 32'h5555_5555);

        // Clear C: latch CMP 3,5 -> flags N only
        applyStimulus(4'b1010, 32'd3, 32'd5, 1'b1);
        stepEdge();
        applyStimulus(4'b0110, 32'd5, 32'd2, 1'b0);
        checkOutput("c0_latched", {28'd0, flags_o}, 32'h2);
        checkOutput("sbc_c0", result_o, 32'd2);
        applyStimulus(4'b0101, 32'd1, 32'd1, 1'b0);
        checkOutput("adc_c0", result_o, 32'd2);

        // Same-cycle forwarding: registered Z=0, CMP 5,5 in EX, BEQ in ID
        applyBranch(4'b0000, 1'b1, 1'b0, 32'h10, 24'hFFFFFE);
        checkOutput("beq_no_fwd", {31'd0, cond_true_o}, 32'd0);
        applyStimulus(4'b1010, 32'd5, 32'd5, 1'b1);
        checkOutput("beq_fwd_cond", {31'd0, cond_true_o}, 32'd1);
        checkOutput("beq_fwd_taken", {31'd0, taken_o}, 32'd1);
        checkOutput("beq_fwd_link", {31'd0, link_we_o}, 32'd0);
        checkOutput("beq_target", target_o, 32'h08);
        stepEdge();

        // BL always / never
        applyStimulus(4'b0100, 32'd1, 32'd1, 1'b0);
        applyBranch(4'b1110, 1'b0, 1'b1, 32'h20, 24'd3);
        checkOutput("bl_al_target", target_o, 32'h2C);
        checkOutput("bl_al_taken", {31'd0, taken_o}, 32'd1);
        checkOutput("bl_al_link", {31'd0, link_we_o}, 32'd1);
        applyBranch(4'b1111, 1'b1, 1'b1, 32'h20, 24'd3);
        checkOutput("bl_nv_taken", {31'd0, taken_o}, 32'd0);
        checkOutput("bl_nv_link", {31'd0, link_we_o}, 32'd0);

        // Registered flags = Z,C set; s_i=0 so ADD 1+1 (Z=0) is not forwarded
        checkOutput("hold_flags_a", {28'd0, flags_o}, 32'hC);
        applyBranch(4'b0001, 1'b1, 1'b0, 32'h40, 24'd0);
        checkOutput("ne_registered", {31'd0, cond_true_o}, 32'd0);
        applyBranch(4'b1000, 1'b1, 1'b0, 32'h40, 24'd0);
        checkOutput("hi_registered", {31'd0, cond_true_o}, 32'd0);
        applyBranch(4'b1101, 1'b1, 1'b0, 32'h40, 24'd0);
        checkOutput("le_registered", {31'd0, cond_true_o}, 32'd1);
        stepEdge();
        stepEdge();
        checkOutput("hold_flags_b", {28'd0, flags_o}, 32'hC);
        applyBranch(4'b0001, 1'b1, 1'b0, 32'h40, 24'd0);
        checkOutput("ne_after_hold", {31'd0, taken_o}, 32'd0);
        applyBranch(4'b1011, 1'b1, 1'b0, 32'h40, 24'd0);
        checkOutput("lt_registered", {31'd0, cond_true_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ex_alu_branch_unit.md
Name: ex_alu_branch_unit

Overview:
- Execute-stage datapath core of the 5-stage ARM-subset pipeline.
- Contains the 32-bit ALU (16 ARM data-processing opcodes, NZCV flags), the persistent flag register, the ARM condition evaluator, the branch target adder and the branch/link condition handler.
- Outputs drive the ALU result into EX/MEM and forwarding, the PC-select/IF-ID flush, and the R14 link write in the register file.

Parameters:
- none (datapath fixed at 32 bits, offset fixed at 24 bits)

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- a_i  in  32  ALU operand A (Rn)
- b_i  in  32  ALU operand B (shifter/immediate output)
- op_i  in  4  ALU opcode (ARM bits 24:21)
- s_i  in  1  set-flags enable for the instruction currently in EX
- cond_i  in  4  condition field of the instruction in ID
- b_instr_i  in  1  ID instruction is B
- bl_instr_i  in  1  ID instruction is BL
- pc4_i  in  32  PC+4 of the ID instruction
- offset_i  in  24  signed branch word offset
- result_o  out  32  ALU result
- alu_flags_o  out  4  combinational flags of the current op
- flags_o  out  4  registered flags
- cond_true_o  out  1  condition passes
- target_o  out  32  branch target address
- taken_o  out  1  select target and flush IF/ID
- link_we_o  out  1  write pc4_i into R14

Behaviour:
- Flag encoding for all 4-bit flag buses: [3]=Z, [2]=C, [1]=N, [0]=V.
- ALU is combinational. Carry-in is flags_o[2].
  - 0000 AND a&b
  - 0001 EOR a^b
  - 0010 SUB a-b
  - 0011 RSB b-a
  - 0100 ADD a+b
  - 0101 ADC a+b+c
  - 0110 SBC a-b-!c
  - 0111 RSC b-a-!c
  - 1000 TST a&b
  - 1001 TEQ a^b
  - 1010 CMP a-b
  - 1011 CMN a+b
  - 1100 ORR a|b
  - 1101 MOV b
  - 1110 BIC a&~b
  - 1111 MVN ~b
- TST, TEQ, CMP and CMN still drive result_o; the pipeline suppresses their writeback.
- Arithmetic is computed as a 33-bit sum with subtraction as x+~y+1.
  - C = bit 32 of that sum, so C=1 means no borrow.
  - V = signed overflow of the operand pair actually added.
- Logical ops: C = current flags_o[2], V = current flags_o[0].
- All ops: N = result[31], Z = (result==0).
- Flag register:
  - On CLR, flags_o = 0 immediately.
  - On posedge CLK with s_i=1, flags_o <= alu_flags_o. Otherwise it holds.
- Effective flags for condition evaluation = s_i ? alu_flags_o : flags_o. This is same-cycle forwarding of the flag-setting instruction in EX to the branch in ID.
- Conditions:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z
  - GE N==V; LT N!=V
  - GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 = 0 (never)
- Target adder: target_o = pc4_i + ({{8{offset_i[23]}},offset_i} << 2), mod 2^32, combinational.
- Condition handler:
  - taken_o = cond_true_o & (b_instr_i | bl_instr_i)
  - link_we_o = cond_true_o & bl_instr_i
  - B and BL both asserted is treated as BL.
- During CLR: taken_o and link_we_o are forced to 0. Combinational outputs otherwise track their inputs with zero latency.
- Reset mid-operation discards any pending flag update.

Decomposition:
- Shared package holds:
  - ALU opcode constants (OP_AND..OP_MVN)
  - condition constants (COND_EQ..COND_NV)
  - flag bit index constants (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0)
- One natural sub-module: ex_alu_core, the combinational ALU and flag generator.
- Flag register, condition evaluator, target adder and handler stay in the top as small always blocks.

Test Plan:
- Reset: with flags nonzero, assert CLR -> flags_o=0 with no clock edge; taken_o=0 and link_we_o=0.
- ADD overflow: op=0100, a=0x7FFFFFFF, b=1, s_i=1 -> result 0x80000000, N=1, V=1, C=0, Z=0; flags_o latched at the next edge.
- SUB/CMP carry: op=1010, a=5, b=5 -> result 0, Z=1, C=1. Then a=3, b=5 -> 0xFFFFFFFE, N=1, C=0.
- ADC/SBC with registered C=1: ADC a=1, b=1 -> 3. SBC a=5, b=2 -> 3. With C=0, SBC a=5, b=2 -> 2.
- Branch forwarding: CMP 5,5 with s_i=1 in EX; ID carries BEQ (cond=0000, b=1), pc4=0x10, offset=0xFFFFFE.
  - Expect cond_true_o=1, taken_o=1, target_o=0x08 in the same cycle.
- BL conditions:
  - BL with cond=1110, pc4=0x20, offset=3 -> target_o=0x2C, taken_o=1, link_we_o=1.
  - cond=1111 -> taken_o=0, link_we_o=0.
  - With s_i=0, flags_o unchanged across edges; NE uses registered Z.
